// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D cacheline arbiter: FSM state encoding, grant side and bus width defaults.
package arb_types;

  localparam int DEF_LINE_W = 256;
  localparam int DEF_ADDR_W = 32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BUSY_I = 3'd1,
    S_BUSY_D = 3'd2,
    S_RESP_I = 3'd3,
    S_RESP_D = 3'd4
  } arb_state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the I-cache, D-cache, arbiter and physical memory.
interface mem_arbiter_if #(
  parameter int LINE_W = arb_types::DEF_LINE_W,
  parameter int ADDR_W = arb_types::DEF_ADDR_W
) ();

  logic              i_read_i;
  logic [ADDR_W-1:0] i_addr_i;
  logic [LINE_W-1:0] i_rdata_o;
  logic              i_resp_o;

  logic              d_read_i;
  logic              d_write_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [LINE_W-1:0] d_wdata_i;
  logic [LINE_W-1:0] d_rdata_o;
  logic              d_resp_o;

  logic              pmem_read_o;
  logic              pmem_write_o;
  logic [ADDR_W-1:0] pmem_addr_o;
  logic [LINE_W-1:0] pmem_wdata_o;
  logic [LINE_W-1:0] pmem_rdata_i;
  logic              pmem_resp_i;

  // slave: the arbiter itself; master: caches plus physical memory around it
  modport slave (
    input  i_read_i, i_addr_i, d_read_i, d_write_i, d_addr_i, d_wdata_i,
           pmem_rdata_i, pmem_resp_i,
    output i_rdata_o, i_resp_o, d_rdata_o, d_resp_o,
           pmem_read_o, pmem_write_o, pmem_addr_o, pmem_wdata_o
  );

  modport master (
    output i_read_i, i_addr_i, d_read_i, d_write_i, d_addr_i, d_wdata_i,
           pmem_rdata_i, pmem_resp_i,
    input  i_rdata_o, i_resp_o, d_rdata_o, d_resp_o,
           pmem_read_o, pmem_write_o, pmem_addr_o, pmem_wdata_o
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-client cacheline arbiter in front of a single-outstanding physical memory port.
// state  | meaning
// IDLE   | no transaction; pick a side, latch its address/data/op
// BUSY_I | I-side line read in flight on pmem
// BUSY_D | D-side read or write-back in flight on pmem
// RESP_I | one-cycle i_resp_o pulse
// RESP_D | one-cycle d_resp_o pulse
module mem_arbiter #(
  parameter int LINE_W = arb_types::DEF_LINE_W,
  parameter int ADDR_W = arb_types::DEF_ADDR_W
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);
  import arb_types::*;

  localparam logic [2:0] IDLE   = S_IDLE;
  localparam logic [2:0] BUSY_I = S_BUSY_I;
  localparam logic [2:0] BUSY_D = S_BUSY_D;
  localparam logic [2:0] RESP_I = S_RESP_I;
  localparam logic [2:0] RESP_D = S_RESP_D;

  logic [2:0]        state;
  grant_e            last_grant;
  logic              op_write;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] i_rdata_q;
  logic [LINE_W-1:0] d_rdata_q;

  logic i_req;
  logic d_req;
  logic pick_d;
  logic busy;

  // D wins a tie unless it also won the previous grant
  always_comb begin
    i_req  = bus.i_read_i;
    d_req  = bus.d_read_i | bus.d_write_i;
    pick_d = d_req & (~i_req | (last_grant == GRANT_I));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      op_write   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req | d_req) begin
            state      <= pick_d ? BUSY_D : BUSY_I;
            last_grant <= pick_d ? GRANT_D : GRANT_I;
            addr_q     <= pick_d ? bus.d_addr_i : bus.i_addr_i;
            wdata_q    <= bus.d_wdata_i;
            // a simultaneous read+write from D is treated as the write-back
            op_write   <= pick_d & bus.d_write_i;
          end
        end
        BUSY_I: begin
          if (bus.pmem_resp_i) begin
            state     <= RESP_I;
            i_rdata_q <= bus.pmem_rdata_i;
          end
        end
        BUSY_D: begin
          if (bus.pmem_resp_i) begin
            state <= RESP_D;
            if (!op_write) d_rdata_q <= bus.pmem_rdata_i;
          end
        end
        RESP_I:  state <= IDLE;
        RESP_D:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy             = (state == BUSY_I) | (state == BUSY_D);
  assign bus.pmem_read_o  = busy & ~op_write;
  assign bus.pmem_write_o = busy & op_write;
  assign bus.pmem_addr_o  = addr_q;
  assign bus.pmem_wdata_o = wdata_q;
  assign bus.i_resp_o     = (state == RESP_I);
  assign bus.d_resp_o     = (state == RESP_D);
  assign bus.i_rdata_o    = i_rdata_q;
  assign bus.d_rdata_o    = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural pmem model plus response and pmem-request scoreboards.
module tb_mem_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.LINE_W(LW), .ADDR_W(AW)) bus ();

  mem_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    bit          side_d;
    logic [LW-1:0] data;
  } resp_t;

  typedef struct {
    bit          write;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } pm_t;

  resp_t sb[$];
  pm_t   pq[$];
  resp_t re_i;
  resp_t re_d;
  pm_t   pe;

  int n_cmp = 0;
  int n_err = 0;

  int mem_lat = 3;
  int cyc = 0;
  int strobe_cnt = 0;
  int stray_req = 0;
  int stray_done = 0;
  int n_i_resp = 0;
  int n_d_resp = 0;
  bit prev_i = 1'b0;
  bit prev_d = 1'b0;
  logic [LW-1:0] last_d = '0;

  task automatic check_eq(string tag, logic [LW-1:0] got, logic [LW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] line_for(logic [AW-1:0] a);
    if (a == 32'h0000_0040) return {32{8'hA5}};
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  // physical memory: answers after mem_lat strobe cycles, checks each new request
  initial begin
    bus.pmem_resp_i  = 1'b0;
    bus.pmem_rdata_i = '0;
    forever begin
      @(negedge clk);
      bus.pmem_resp_i = 1'b0;
      if (!rst_n) begin
        cyc = 0;
      end else if (bus.pmem_read_o || bus.pmem_write_o) begin
        strobe_cnt++;
        cyc++;
        if (cyc == 1) begin
          if (pq.size() == 0) begin
            check_eq("pmem_unexpected", LW'(1), LW'(0));
          end else begin
            pe = pq.pop_front();
            check_eq("pmem_op", LW'({bus.pmem_write_o, bus.pmem_read_o}),
                     LW'(pe.write ? 2'b10 : 2'b01));
            check_eq("pmem_addr", LW'(bus.pmem_addr_o), LW'(pe.addr));
            if (pe.write) check_eq("pmem_wdata", bus.pmem_wdata_o, pe.wdata);
          end
        end
        if (cyc >= mem_lat) begin
          bus.pmem_resp_i  = 1'b1;
          bus.pmem_rdata_i = line_for(bus.pmem_addr_o);
          cyc = 0;
        end
      end else if (stray_req != stray_done) begin
        stray_done++;
        bus.pmem_resp_i  = 1'b1;
        bus.pmem_rdata_i = '1;
      end
    end
  end

  // response monitor: every pulse pops the scoreboard in order
  initial begin
    forever begin
      @(negedge clk);
      if (bus.i_resp_o) begin
        n_i_resp++;
        check_eq("i_resp_1cyc", LW'(prev_i), LW'(0));
        if (sb.size() == 0) begin
          check_eq("i_resp_unexpected", LW'(1), LW'(0));
        end else begin
          re_i = sb.pop_front();
          check_eq("i_resp_side", LW'(re_i.side_d), LW'(0));
          check_eq("i_rdata", bus.i_rdata_o, re_i.data);
        end
      end
      if (bus.d_resp_o) begin
        n_d_resp++;
        check_eq("d_resp_1cyc", LW'(prev_d), LW'(0));
        if (sb.size() == 0) begin
          check_eq("d_resp_unexpected", LW'(1), LW'(0));
        end else begin
          re_d = sb.pop_front();
          check_eq("d_resp_side", LW'(re_d.side_d), LW'(1));
          check_eq("d_rdata", bus.d_rdata_o, re_d.data);
        end
      end
      prev_i = bus.i_resp_o;
      prev_d = bus.d_resp_o;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic exp_i(logic [AW-1:0] a);
    sb.push_back('{side_d: 1'b0, data: line_for(a)});
    pq.push_back('{write: 1'b0, addr: a, wdata: '0});
  endtask

  task automatic exp_d_read(logic [AW-1:0] a);
    last_d = line_for(a);
    sb.push_back('{side_d: 1'b1, data: last_d});
    pq.push_back('{write: 1'b0, addr: a, wdata: '0});
  endtask

  task automatic exp_d_write(logic [AW-1:0] a, logic [LW-1:0] w);
    sb.push_back('{side_d: 1'b1, data: last_d});
    pq.push_back('{write: 1'b1, addr: a, wdata: w});
  endtask

  // hold requests until each side's resp pulse, then drop that side
  task automatic serve(int budget);
    int k;
    k = 0;
    while ((bus.i_read_i || bus.d_read_i || bus.d_write_i) && k < budget) begin
      @(negedge clk);
      #1;
      if (bus.i_resp_o) bus.i_read_i = 1'b0;
      if (bus.d_resp_o) begin
        bus.d_read_i  = 1'b0;
        bus.d_write_i = 1'b0;
      end
      k++;
    end
    check_eq("serve_done", LW'(bus.i_read_i | bus.d_read_i | bus.d_write_i), LW'(0));
  endtask

  initial begin
    int s0;
    int r0;
    int di;
    int ii;
    int k;
    logic [AW-1:0] da[3];
    logic [AW-1:0] ia[3];
    logic [LW-1:0] wline;

    bus.i_read_i  = 1'b0;
    bus.i_addr_i  = '0;
    bus.d_read_i  = 1'b0;
    bus.d_write_i = 1'b0;
    bus.d_addr_i  = '0;
    bus.d_wdata_i = '0;
    tick(3);

    check_eq("rst_pmem_read", LW'(bus.pmem_read_o), LW'(0));
    check_eq("rst_pmem_write", LW'(bus.pmem_write_o), LW'(0));
    check_eq("rst_i_resp", LW'(bus.i_resp_o), LW'(0));
    check_eq("rst_d_resp", LW'(bus.d_resp_o), LW'(0));
    check_eq("rst_pmem_addr", LW'(bus.pmem_addr_o), LW'(0));
    check_eq("rst_i_rdata", bus.i_rdata_o, LW'(0));
    check_eq("rst_d_rdata", bus.d_rdata_o, LW'(0));
    rst_n = 1'b1;
    tick(2);

    // stray pmem response while idle
    s0 = strobe_cnt;
    r0 = n_i_resp + n_d_resp;
    stray_req++;
    tick(4);
    check_eq("stray_no_strobe", LW'(strobe_cnt - s0), LW'(0));
    check_eq("stray_no_resp", LW'(n_i_resp + n_d_resp - r0), LW'(0));

    // simultaneous I and D reads right after reset: D first
    exp_d_read(32'h0000_1100);
    exp_i(32'h0000_2200);
    bus.d_addr_i = 32'h0000_1100;
    bus.i_addr_i = 32'h0000_2200;
    bus.d_read_i = 1'b1;
    bus.i_read_i = 1'b1;
    serve(100);
    tick(2);

    // D write-back: rdata must not move
    wline = {16{16'h1234}};
    exp_d_write(32'h8000_0100, wline);
    bus.d_addr_i  = 32'h8000_0100;
    bus.d_wdata_i = wline;
    bus.d_write_i = 1'b1;
    serve(100);
    tick(2);
    check_eq("wr_d_rdata_hold", bus.d_rdata_o, last_d);

    // read and write together: the write wins
    wline = {8{32'hDEAD_BEEF}};
    exp_d_write(32'h0000_3300, wline);
    bus.d_addr_i  = 32'h0000_3300;
    bus.d_wdata_i = wline;
    bus.d_read_i  = 1'b1;
    bus.d_write_i = 1'b1;
    serve(100);
    tick(2);

    // single I read at 0x40 with a 3-cycle memory
    mem_lat = 3;
    s0 = strobe_cnt;
    r0 = n_i_resp;
    exp_i(32'h0000_0040);
    bus.i_addr_i = 32'h0000_0040;
    bus.i_read_i = 1'b1;
    tick(1);
    check_eq("strobe_latency", LW'(bus.pmem_read_o), LW'(1));
    serve(100);
    tick(3);
    check_eq("i_strobe_cycles", LW'(strobe_cnt - s0), LW'(3));
    check_eq("i_resp_count", LW'(n_i_resp - r0), LW'(1));
    check_eq("i_rdata_hold", bus.i_rdata_o, {32{8'hA5}});

    // continuous contention: grants must alternate D,I,D,I,D,I
    mem_lat = 2;
    for (int j = 0; j < 3; j++) begin
      da[j] = 32'h0000_4000 + AW'(j * 64);
      ia[j] = 32'h0000_5000 + AW'(j * 64);
    end
    for (int j = 0; j < 3; j++) begin
      exp_d_read(da[j]);
      exp_i(ia[j]);
    end
    di = 0;
    ii = 0;
    k  = 0;
    bus.d_addr_i = da[0];
    bus.i_addr_i = ia[0];
    bus.d_read_i = 1'b1;
    bus.i_read_i = 1'b1;
    while ((bus.d_read_i || bus.i_read_i) && k < 300) begin
      @(negedge clk);
      #1;
      if (bus.d_resp_o) begin
        di++;
        if (di < 3) bus.d_addr_i = da[di];
        else bus.d_read_i = 1'b0;
      end
      if (bus.i_resp_o) begin
        ii++;
        if (ii < 3) bus.i_addr_i = ia[ii];
        else bus.i_read_i = 1'b0;
      end
      k++;
    end
    check_eq("alt_d_count", LW'(di), LW'(3));
    check_eq("alt_i_count", LW'(ii), LW'(3));
    tick(2);

    // reset while BUSY_D abandons the transaction
    mem_lat = 20;
    pq.push_back('{write: 1'b0, addr: 32'h0000_6600, wdata: '0});
    bus.d_addr_i = 32'h0000_6600;
    bus.d_read_i = 1'b1;
    k = 0;
    while (!bus.pmem_read_o && k < 20) begin
      tick(1);
      k++;
    end
    tick(1);
    check_eq("busy_before_rst", LW'(bus.pmem_read_o), LW'(1));
    r0 = n_d_resp;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_pmem_read", LW'(bus.pmem_read_o), LW'(0));
    check_eq("midrst_pmem_addr", LW'(bus.pmem_addr_o), LW'(0));
    check_eq("midrst_d_resp", LW'(bus.d_resp_o), LW'(0));
    check_eq("midrst_d_rdata", bus.d_rdata_o, LW'(0));
    check_eq("midrst_i_rdata", bus.i_rdata_o, LW'(0));
    bus.d_read_i = 1'b0;
    tick(2);
    rst_n = 1'b1;
    stray_req++;
    tick(4);
    check_eq("midrst_no_d_resp", LW'(n_d_resp - r0), LW'(0));
    check_eq("midrst_idle", LW'(bus.pmem_read_o | bus.pmem_write_o), LW'(0));

    // normal service after the abandoned transaction
    mem_lat = 3;
    exp_d_read(32'h0000_7700);
    bus.d_addr_i = 32'h0000_7700;
    bus.d_read_i = 1'b1;
    serve(100);
    tick(3);

    check_eq("sb_empty", LW'(sb.size()), LW'(0));
    check_eq("pq_empty", LW'(pq.size()), LW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
